motion_detector: RTL

Block-based frame-difference motion detector on the camera capture path. Consumes the 320x240 RGB444 pixel stream produced by capture (same pixels and write strobe that go into the frame BRAM), reduces each 16x16 block to a luminance sum, and compares each sum against the previous frame's value. Reports per frame the number of changed blocks and a motion alarm for the alarm/overlay logic.

---
 rtl/md_pkg.sv | 26 ++
 rtl/motion_detector_if.sv | 24 ++
 rtl/md_sum_ram.sv | 21 ++
 rtl/motion_detector.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// motion_detector shared types, widths and helpers.
// Block geometry defaults, pipeline bundle and RGB444 gray reduction.
package md_pkg;

  localparam int H_BLKS   = 20;
  localparam int V_BLKS   = 15;
  localparam int NUM_BLKS = 300;
  localparam int SUM_W    = 14;
  localparam int CNT_W    = 9;
  localparam int BLK_LOG2 = 4;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int ADDR_W   = 9;

  typedef struct packed {
    logic              vld;
    logic              last;
    logic [ADDR_W-1:0] idx;
    logic [SUM_W-1:0]  sum;
  } fin_t;

  function automatic logic [5:0] gray(input logic [11:0] p);
    return {2'b00, p[11:8]} + {2'b00, p[7:4]} + {2'b00, p[3:0]};
  endfunction

endpackage

// File: rtl/motion_detector_if.sv
// motion_detector pixel-in / result-out bundle.
// master: capture side (frame_start, pix_valid, pix_data); slave: detector.
interface motion_detector_if;
  import md_pkg::*;

  logic             frame_start;
  logic             pix_valid;
  logic [11:0]      pix_data;
  logic             frame_done;
  logic [CNT_W-1:0] changed_cnt;
  logic             alarm;
  logic             busy;

  modport master (
    output frame_start, pix_valid, pix_data,
    input  frame_done, changed_cnt, alarm, busy
  );

  modport slave (
    input  frame_start, pix_valid, pix_data,
    output frame_done, changed_cnt, alarm, busy
  );

endinterface

// File: rtl/md_sum_ram.sv
// Previous-frame block-sum store: 300x14 simple dual port.
// Ports: i_we/i_waddr/i_wdata write, i_raddr -> o_rdata one cycle later (old data on collision).
module md_sum_ram
  import md_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [SUM_W-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [SUM_W-1:0]  o_rdata
);

  logic [SUM_W-1:0] r_mem [NUM_BLKS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/motion_detector.sv
// Block-based frame-difference motion detector (16x16 block luma sums).
// Ports: clk, rst_n (async low), bus (slave). Macro MD_HYSTERESIS_EN: 2-frame alarm hysteresis.
module motion_detector
  import md_pkg::*;
#(
  parameter int H_RES    = 320,
  parameter int V_RES    = 240,
  parameter int DIFF_TH  = 512,
  parameter int COUNT_TH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  motion_detector_if.slave  bus
);

  localparam int L_HB = H_RES >> BLK_LOG2;

  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic             r_all;
  logic             r_busy;
  logic             r_primed;
  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] r_acc [H_BLKS];
  fin_t             r_s1;
  logic             r_s2_vld;
  logic             r_s2_last;
  logic [SUM_W-1:0] r_s2_sum;
  logic             r_s3_last;
  logic             r_done;
  logic [CNT_W-1:0] r_chg_cnt;
  logic             r_alarm;
`ifdef MD_HYSTERESIS_EN
  logic             r_hist;
`endif

  logic [4:0]        w_col;
  logic [3:0]        w_row;
  logic [5:0]        w_gray;
  logic [SUM_W-1:0]  w_sum;
  logic              w_start;
  logic              w_acc;
  logic              w_blk_end;
  logic              w_fin;
  logic              w_last;
  logic [ADDR_W-1:0] w_idx;
  logic [SUM_W-1:0]  w_prev;
  logic [SUM_W-1:0]  w_diff;
  logic              w_chg;
  logic              w_met;

  assign w_col  = r_x[X_W-1:BLK_LOG2];
  assign w_row  = r_y[Y_W-1:BLK_LOG2];
  assign w_gray = gray(bus.pix_data);
  assign w_sum  = r_acc[w_col] + SUM_W'(w_gray);

  // A frame_start arriving after the last pixel, while the result is
  // still draining, would corrupt the running count; it is not an abort.
  assign w_start = bus.frame_start && !(r_busy && r_all);
  assign w_acc   = bus.pix_valid && r_busy && !r_all && !bus.frame_start;

  assign w_blk_end = (&r_x[BLK_LOG2-1:0]) && (&r_y[BLK_LOG2-1:0]);
  assign w_fin     = w_acc && w_blk_end;
  assign w_last    = w_acc && (r_x == X_W'(H_RES - 1))
                           && (r_y == Y_W'(V_RES - 1));
  assign w_idx     = ADDR_W'(w_row) * ADDR_W'(L_HB) + ADDR_W'(w_col);

  md_sum_ram u_ram (
    .clk     (clk),
    .i_we    (r_s1.vld),
    .i_waddr (r_s1.idx),
    .i_wdata (r_s1.sum),
    .i_raddr (r_s1.idx),
    .o_rdata (w_prev)
  );

  assign w_diff = (r_s2_sum >= w_prev) ? r_s2_sum - w_prev
                                       : w_prev - r_s2_sum;
  assign w_chg  = r_s2_vld && r_primed && (w_diff > SUM_W'(DIFF_TH));
  assign w_met  = r_primed && (r_cnt >= CNT_W'(COUNT_TH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x       <= '0;
      r_y       <= '0;
      r_all     <= 1'b0;
      r_busy    <= 1'b0;
      r_primed  <= 1'b0;
      r_cnt     <= '0;
      r_s1      <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_last <= 1'b0;
      r_s2_sum  <= '0;
      r_s3_last <= 1'b0;
      r_done    <= 1'b0;
      r_chg_cnt <= '0;
      r_alarm   <= 1'b0;
`ifdef MD_HYSTERESIS_EN
      r_hist    <= 1'b0;
`endif
      for (int i = 0; i < H_BLKS; i++) r_acc[i] <= '0;
    end else begin
      r_done    <= 1'b0;
      r_s1      <= '{vld: w_fin, last: w_last, idx: w_idx, sum: w_sum};
      r_s2_vld  <= r_s1.vld;
      r_s2_last <= r_s1.last;
      r_s2_sum  <= r_s1.sum;
      r_s3_last <= r_s2_vld && r_s2_last;
      if (w_chg) r_cnt <= r_cnt + 1'b1;

      if (w_acc) begin
        r_acc[w_col] <= w_blk_end ? '0 : w_sum;
        if (r_x == X_W'(H_RES - 1)) begin
          r_x <= '0;
          r_y <= r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
        if (w_last) r_all <= 1'b1;
      end

      if (r_s3_last) begin
        r_done    <= 1'b1;
        r_chg_cnt <= r_cnt;
        r_busy    <= 1'b0;
        r_primed  <= 1'b1;
`ifdef MD_HYSTERESIS_EN
        r_hist    <= w_met;
        if (w_met && r_hist)        r_alarm <= 1'b1;
        else if (!w_met && !r_hist) r_alarm <= 1'b0;
`else
        r_alarm   <= w_met;
`endif
      end

      if (w_start) begin
        // Restart while busy is an abort: the previous-frame RAM is now
        // partly overwritten, so the next frame cannot be compared.
        if (r_busy) r_primed <= 1'b0;
        r_busy    <= 1'b1;
        r_x       <= '0;
        r_y       <= '0;
        r_all     <= 1'b0;
        r_cnt     <= '0;
        r_s1      <= '0;
        r_s2_vld  <= 1'b0;
        r_s3_last <= 1'b0;
        for (int i = 0; i < H_BLKS; i++) r_acc[i] <= '0;
      end
    end
  end

  assign bus.frame_done  = r_done;
  assign bus.changed_cnt = r_chg_cnt;
  assign bus.alarm       = r_alarm;
  assign bus.busy        = r_busy;

endmodule
